// File: rtl/if_id_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : if_id_skid_buffer
// Purpose  : IF->ID pipeline register with a valid/ready handshake and a
//            two-entry skid stage. Decode can stall without a combinational
//            ready path back to fetch. A flush discards all in-flight
//            fetches. When no valid entry is held, decode receives a NOP
//            bubble.
// Ports    : clock              - rising-edge clock
//            reset              - synchronous active-high reset; clears all state
//            flush              - synchronous; drops held and incoming entries
//            if_valid/if_ready  - fetch-side handshake
//            if_program_counter - fetched pc
//            if_instruction     - fetched instruction word
//            id_valid/id_ready  - decode-side handshake
//            id_program_counter - main-entry pc, or BUBBLE_PC when invalid
//            id_instruction     - main-entry instruction, or NOP when invalid
//            occupancy          - number of valid entries held (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module if_id_skid_buffer #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTRUCTION = '0,
  parameter logic [ADDR_WIDTH-1:0] BUBBLE_PC       = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [ADDR_WIDTH-1:0] if_program_counter,
  input  logic [DATA_WIDTH-1:0] if_instruction,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [ADDR_WIDTH-1:0] id_program_counter,
  output logic [DATA_WIDTH-1:0] id_instruction,
  output logic [1:0]            occupancy
);

  // State values double as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [ADDR_WIDTH-1:0] r_m_pc;
  logic [DATA_WIDTH-1:0] r_m_instr;
  logic [ADDR_WIDTH-1:0] r_s_pc;
  logic [DATA_WIDTH-1:0] r_s_instr;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_load_m_in;
  logic                  w_load_m_skid;
  logic                  w_load_s;

  // if_ready depends only on registered state (plus reset), never on id_ready.
  assign if_ready   = (r_state != ST_FULL) && !reset;
  assign id_valid   = (r_state != ST_EMPTY);
  assign occupancy  = r_state;

  assign w_in_fire  = if_valid & if_ready;
  assign w_out_fire = id_valid & id_ready;

  // Bubble values mask whatever is left in M when nothing valid is held.
  assign id_program_counter = id_valid ? r_m_pc    : BUBBLE_PC;
  assign id_instruction     = id_valid ? r_m_instr : NOP_INSTRUCTION;

  always_comb begin
    w_state_next  = r_state;
    w_load_m_in   = 1'b0;
    w_load_m_skid = 1'b0;
    w_load_s      = 1'b0;

    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_next = ST_ONE;
          w_load_m_in  = 1'b1;
        end
      end
      ST_ONE: begin
        case ({w_in_fire, w_out_fire})
          2'b10: begin
            w_state_next = ST_FULL;
            w_load_s     = 1'b1;
          end
          2'b01: begin
            w_state_next = ST_EMPTY;
          end
          2'b11: begin
            w_load_m_in  = 1'b1;
          end
          default: begin
            w_state_next = ST_ONE;
          end
        endcase
      end
      ST_FULL: begin
        // if_ready is low here, so no input can fire.
        if (w_out_fire) begin
          w_state_next  = ST_ONE;
          w_load_m_skid = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase

    // Flush wins over the handshakes; an out_fire this cycle is still consumed.
    if (flush) begin
      w_state_next  = ST_EMPTY;
      w_load_m_in   = 1'b0;
      w_load_m_skid = 1'b0;
      w_load_s      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_EMPTY;
      r_m_pc    <= '0;
      r_m_instr <= '0;
      r_s_pc    <= '0;
      r_s_instr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_m_in) begin
        r_m_pc    <= if_program_counter;
        r_m_instr <= if_instruction;
      end else if (w_load_m_skid) begin
        r_m_pc    <= r_s_pc;
        r_m_instr <= r_s_instr;
      end
      if (w_load_s) begin
        r_s_pc    <= if_program_counter;
        r_s_instr <= if_instruction;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_skid_buffer
// Purpose  : Self-checking bench for if_id_skid_buffer. A queue-based FIFO
//            reference (capacity 2) predicts every output each cycle.
//            Directed scenarios run first, followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_skid_buffer;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam logic [DW-1:0] NOP = 32'h0000_0000;
  localparam logic [AW-1:0] BPC = 32'h0000_0000;

  logic          clock;
  logic          reset;
  logic          flush;
  logic          if_valid;
  logic          if_ready;
  logic [AW-1:0] if_program_counter;
  logic [DW-1:0] if_instruction;
  logic          id_valid;
  logic          id_ready;
  logic [AW-1:0] id_program_counter;
  logic [DW-1:0] id_instruction;
  logic [1:0]    occupancy;

  if_id_skid_buffer #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .NOP_INSTRUCTION (NOP),
    .BUBBLE_PC       (BPC)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .if_valid           (if_valid),
    .if_ready           (if_ready),
    .if_program_counter (if_program_counter),
    .if_instruction     (if_instruction),
    .id_valid           (id_valid),
    .id_ready           (id_ready),
    .id_program_counter (id_program_counter),
    .id_instruction     (id_instruction),
    .occupancy          (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: ordered list of held entries, {pc, instr}, head is what ID shows.
  logic [63:0] q[$];
  bit          model_known = 0;
  bit          last_in_fire;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the reference as the coming rising edge will.
  task automatic step(input logic rst, input logic fl, input logic v,
                      input logic [AW-1:0] pc, input logic [DW-1:0] ins,
                      input logic rdy);
    bit exp_valid;
    bit exp_ready;
    bit in_f;
    bit out_f;
    @(negedge clock);
    reset              = rst;
    flush              = fl;
    if_valid           = v;
    if_program_counter = pc;
    if_instruction     = ins;
    id_ready           = rdy;
    #1;
    exp_valid = (q.size() != 0);
    exp_ready = (q.size() < 2) && !rst;
    if (model_known) begin
      check_val("id_valid", 64'(id_valid), 64'(exp_valid));
      check_val("id_pc",    64'(id_program_counter), exp_valid ? 64'(q[0][63:32]) : 64'(BPC));
      check_val("id_instr", 64'(id_instruction),     exp_valid ? 64'(q[0][31:0])  : 64'(NOP));
      check_val("occupancy", 64'(occupancy), 64'(q.size()));
      check_val("if_ready", 64'(if_ready), 64'(exp_ready));
    end
    in_f  = v && exp_ready;
    out_f = exp_valid && rdy;
    last_in_fire = in_f;
    if (rst) begin
      q.delete();
      model_known = 1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (out_f) void'(q.pop_front());
      if (in_f)  q.push_back({pc, ins});
    end
  endtask

  initial begin
    bit accepted;
    reset = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_program_counter = '0; if_instruction = '0;

    // Reset held two cycles with fetch asserting valid.
    step(1, 0, 1, 32'h100, 32'hDEAD, 0);
    step(1, 0, 1, 32'h100, 32'hDEAD, 0);
    step(0, 0, 0, 32'h0, 32'h0, 0);
    check_val("ready_after_reset", 64'(if_ready), 64'd1);

    // Streaming with decode always ready.
    step(0, 0, 1, 32'h00, 32'hA, 1);
    step(0, 0, 1, 32'h04, 32'hB, 1);
    step(0, 0, 1, 32'h08, 32'hC, 1);
    step(0, 0, 0, 32'h0,  32'h0, 1);
    step(0, 0, 0, 32'h0,  32'h0, 1);

    // Stall and skid: fill both entries, fetch holds 0x08 until accepted.
    step(0, 0, 1, 32'h00, 32'hA, 0);
    step(0, 0, 1, 32'h04, 32'hB, 0);
    accepted = 0;
    for (int k = 0; k < 10 && !accepted; k++) begin
      step(0, 0, 1, 32'h08, 32'hC, (k >= 2));
      accepted = last_in_fire;
    end
    check_val("accept_08", 64'(accepted), 64'd1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 32'h0, 32'h0, 1);

    // Flush in FULL with a simultaneous fetch of 0x0C.
    step(0, 0, 1, 32'h20, 32'h1, 0);
    step(0, 0, 1, 32'h24, 32'h2, 0);
    step(0, 1, 1, 32'h0C, 32'h3, 0);
    step(0, 0, 0, 32'h0,  32'h0, 1);
    step(0, 0, 0, 32'h0,  32'h0, 1);

    // Simultaneous in/out fire in ONE.
    step(0, 0, 1, 32'h10, 32'h10, 0);
    step(0, 0, 1, 32'h14, 32'h14, 1);
    step(0, 0, 0, 32'h0,  32'h0,  0);
    step(0, 0, 0, 32'h0,  32'h0,  1);

    // Mid-operation reset from FULL.
    step(0, 0, 1, 32'h30, 32'h30, 0);
    step(0, 0, 1, 32'h34, 32'h34, 0);
    step(1, 0, 0, 32'h0,  32'h0,  1);
    step(0, 0, 0, 32'h0,  32'h0,  1);
    step(0, 0, 0, 32'h0,  32'h0,  1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 70),
           AW'($urandom), DW'($urandom),
           ($urandom_range(0, 99) < 60));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
